// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_seq fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_e;

    localparam logic [3:0]  OP_BR   = 4'hB;
    localparam logic [3:0]  OP_HALT = 4'hF;
    localparam int unsigned DISP_W  = 12;

endpackage

// File: rtl/pc_seq_br_decode.sv
// Combinational instruction decode into one PC command plus offset magnitude.
module br_decode
    import pc_seq_pkg::*;
(
    input  logic [15:0] instr,
    output logic        inc,
    output logic        add,
    output logic        sub,
    output logic        halt,
    output logic [15:0] offset
);

    logic [3:0]        op;
    logic [DISP_W-1:0] disp;
    logic [DISP_W:0]   mag;

    always_comb begin
        inc    = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        halt   = 1'b0;
        offset = 16'h0000;
        op     = instr[15:12];
        disp   = instr[DISP_W-1:0];
        // One extra bit so the most negative displacement has a representable magnitude.
        mag    = ~{disp[DISP_W-1], disp} + (DISP_W+1)'(1);
        if (op == OP_HALT) begin
            halt = 1'b1;
        end else if (op == OP_BR) begin
            if (disp[DISP_W-1]) begin
                sub    = 1'b1;
                offset = 16'(mag);
            end else if (disp != '0) begin
                add    = 1'b1;
                offset = 16'(disp);
            end
        end else begin
            inc = 1'b1;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch sequencer: imem handshake, timeout, and registered PC command pulses.
// Optional branch counter output br_cnt enabled by defining PC_SEQ_BRCNT_EN.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    input  logic [15:0] pc,
    output logic        imem_req,
    output logic        pc_inc,
    output logic        pc_add,
    output logic        pc_sub,
    output logic [15:0] pc_offset,
    output logic        halted,
    output logic        fault,
`ifdef PC_SEQ_BRCNT_EN
    output logic [15:0] br_cnt,
`endif
    output logic [15:0] last_pc
);

    localparam int unsigned CNT_W = 8;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt_pend_q, halt_pend_d;
    logic               imem_req_q, imem_req_d;
    logic               pc_inc_q, pc_inc_d;
    logic               pc_add_q, pc_add_d;
    logic               pc_sub_q, pc_sub_d;
    logic [15:0]        pc_offset_q, pc_offset_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [15:0]        last_pc_q, last_pc_d;
`ifdef PC_SEQ_BRCNT_EN
    logic [15:0]        br_cnt_q, br_cnt_d;
`endif

    logic               dec_inc, dec_add, dec_sub, dec_halt;
    logic [15:0]        dec_offset;

    // Decode the word on the bus so the command pulse can be registered into EXEC.
    br_decode u_br_decode (
        .instr  (instr),
        .inc    (dec_inc),
        .add    (dec_add),
        .sub    (dec_sub),
        .halt   (dec_halt),
        .offset (dec_offset)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            imem_req_q  <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_add_q    <= 1'b0;
            pc_sub_q    <= 1'b0;
            pc_offset_q <= 16'h0000;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            last_pc_q   <= 16'h0000;
`ifdef PC_SEQ_BRCNT_EN
            br_cnt_q    <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            imem_req_q  <= imem_req_d;
            pc_inc_q    <= pc_inc_d;
            pc_add_q    <= pc_add_d;
            pc_sub_q    <= pc_sub_d;
            pc_offset_q <= pc_offset_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            last_pc_q   <= last_pc_d;
`ifdef PC_SEQ_BRCNT_EN
            br_cnt_q    <= br_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        pc_inc_d    = 1'b0;
        pc_add_d    = 1'b0;
        pc_sub_d    = 1'b0;
        pc_offset_d = 16'h0000;
        last_pc_d   = last_pc_q;
`ifdef PC_SEQ_BRCNT_EN
        br_cnt_d    = br_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (run) state_d = REQ;
            end
            REQ: begin
                // Ack takes priority over the timeout limit in the same cycle.
                if (imem_ack) begin
                    state_d     = EXEC;
                    cnt_d       = '0;
                    last_pc_d   = pc;
                    halt_pend_d = dec_halt;
                    pc_inc_d    = dec_inc;
                    pc_add_d    = dec_add;
                    pc_sub_d    = dec_sub;
                    pc_offset_d = dec_offset;
`ifdef PC_SEQ_BRCNT_EN
                    if (dec_add || dec_sub) br_cnt_d = br_cnt_q + 16'd1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(TMO_CYC)) state_d = FAULT;
                end
            end
            EXEC: begin
                if (halt_pend_q)  state_d = HALT;
                else if (run)     state_d = REQ;
                else              state_d = IDLE;
            end
            HALT: begin
                if (!run) state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        imem_req_d = (state_d == REQ);
        halted_d   = (state_d == HALT);
        fault_d    = (state_d == FAULT);
    end

    assign imem_req  = imem_req_q;
    assign pc_inc    = pc_inc_q;
    assign pc_add    = pc_add_q;
    assign pc_sub    = pc_sub_q;
    assign pc_offset = pc_offset_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    assign last_pc   = last_pc_q;
`ifdef PC_SEQ_BRCNT_EN
    assign br_cnt    = br_cnt_q;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq; covers br_cnt when PC_SEQ_BRCNT_EN is defined.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_ack;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        imem_req;
    logic        pc_inc;
    logic        pc_add;
    logic        pc_sub;
    logic [15:0] pc_offset;
    logic        halted;
    logic        fault;
    logic [15:0] last_pc;
`ifdef PC_SEQ_BRCNT_EN
    logic [15:0] br_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pc_seq #(.TMO_CYC(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .imem_ack  (imem_ack),
        .instr     (instr),
        .pc        (pc),
        .imem_req  (imem_req),
        .pc_inc    (pc_inc),
        .pc_add    (pc_add),
        .pc_sub    (pc_sub),
        .pc_offset (pc_offset),
        .halted    (halted),
        .fault     (fault),
`ifdef PC_SEQ_BRCNT_EN
        .br_cnt    (br_cnt),
`endif
        .last_pc   (last_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view of the three pulses plus offset: {inc, add, sub, offset}.
    function automatic logic [31:0] cmd();
        return {13'd0, pc_inc, pc_add, pc_sub, pc_offset};
    endfunction

    task automatic fetch(input logic [15:0] w, input logic [15:0] p);
        imem_ack = 1'b1;
        instr    = w;
        pc       = p;
        step();
        imem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; instr = 16'h0000; pc = 16'h0100;
        #2;
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_cmd",    cmd(), 32'd0);
        check("rst_status", {30'd0, halted, fault}, 32'd0);
        check("rst_lastpc", {16'd0, last_pc}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("idle_req", {31'd0, imem_req}, 32'd0);

        // Basic fetch: two wait cycles then ack.
        run = 1'b1;
        step();
        check("req_c1", {31'd0, imem_req}, 32'd1);
        step();
        check("req_c2", {31'd0, imem_req}, 32'd1);
        step();
        check("req_c3", {31'd0, imem_req}, 32'd1);
        check("req_nopulse", cmd(), 32'd0);
        fetch(16'h1234, 16'h0100);
        check("inc_cmd",    cmd(), {13'd0, 3'b100, 16'h0000});
        check("inc_req",    {31'd0, imem_req}, 32'd0);
        check("inc_lastpc", {16'd0, last_pc}, 32'h0100);
        step();
        check("back_req", {31'd0, imem_req}, 32'd1);
        check("back_cmd", cmd(), 32'd0);

        fetch(16'hB005, 16'h0101);
        check("add_cmd", cmd(), {13'd0, 3'b010, 16'h0005});
        step();
        fetch(16'hBFFD, 16'h0106);
        check("sub_cmd", cmd(), {13'd0, 3'b001, 16'h0003});
        step();
        fetch(16'hB800, 16'h0103);
        check("sub_max_cmd", cmd(), {13'd0, 3'b001, 16'h0800});
        step();
        fetch(16'hB000, 16'h0080);
        check("br0_cmd", cmd(), 32'd0);
        check("br0_lastpc", {16'd0, last_pc}, 32'h0080);
`ifdef PC_SEQ_BRCNT_EN
        check("brcnt_3", {16'd0, br_cnt}, 32'd3);
`endif
        step();
        check("br0_req", {31'd0, imem_req}, 32'd1);

        // Halt and release.
        fetch(16'hF000, 16'h0200);
        check("halt_exec_cmd", cmd(), 32'd0);
        check("halt_exec_h",   {31'd0, halted}, 32'd0);
        step();
        check("halt_h",   {31'd0, halted}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        step();
        check("halt_hold", {31'd0, halted}, 32'd1);
        run = 1'b0;
        step();
        check("halt_exit",   {31'd0, halted}, 32'd0);
        check("halt_lastpc", {16'd0, last_pc}, 32'h0200);
        step();
        check("idle_stay", {31'd0, imem_req}, 32'd0);

        // Timeout: 15 REQ cycles without ack.
        run = 1'b1;
        step();
        for (int i = 0; i < 14; i++) step();
        check("tmo_c15_req",   {31'd0, imem_req}, 32'd1);
        check("tmo_c15_fault", {31'd0, fault}, 32'd0);
        step();
        check("tmo_fault", {31'd0, fault}, 32'd1);
        check("tmo_req",   {31'd0, imem_req}, 32'd0);
        run = 1'b0;
        step();
        check("fault_sticky", {31'd0, fault}, 32'd1);

        // Ack on exactly the 15th REQ cycle wins.
        reset = 1'b1; #1; reset = 1'b0;
        check("rst_clr_fault", {31'd0, fault}, 32'd0);
        run = 1'b1;
        step();
        for (int i = 0; i < 14; i++) step();
        fetch(16'h1000, 16'h0300);
        check("ack15_cmd",   cmd(), {13'd0, 3'b100, 16'h0000});
        check("ack15_fault", {31'd0, fault}, 32'd0);

        // Reset mid-REQ with ack pending.
        step();
        step();
        check("mid_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1;
        instr    = 16'hB004;
        reset    = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        step();
        check("mid_rst_cmd", cmd(), 32'd0);
`ifdef PC_SEQ_BRCNT_EN
        check("brcnt_rst", {16'd0, br_cnt}, 32'd0);
`endif
        imem_ack = 1'b0;
        reset    = 1'b0;
        step();
        check("post_rst_cmd", cmd(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
